// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-RAM port arbiter: owner encodings,
// codebase-wide bus widths and the byte-to-word address helper.
package mem_port_arbiter_pkg;

  localparam int WORD_BUS      = 32;
  localparam int INST_ADDR_BUS = 32;

  // Which requester owns the RAM read slot in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  // The RAM is word addressed, so the two byte-offset bits are dropped.
  // The caller truncates the result to the RAM address width.
  function automatic logic [INST_ADDR_BUS-1:0] byte_to_word(
    input logic [INST_ADDR_BUS-1:0] byte_addr
  );
    return {2'b00, byte_addr[INST_ADDR_BUS-1:2]};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_starve_sel.sv
// Grant selector: data side has fixed priority, except when the instruction
// side has been denied STARVE_MAX times in a row, in which case it wins once.
module prio_starve_sel #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_MAX);

  // Combinational winner selection; reset blocks every grant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst) begin
      if (i_req && starved) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Count consecutive instruction-side denials, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!i_req || grant_i) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency block RAM between the instruction
// fetch and data access ports. The top holds the RAM mux and the registered
// response owner that routes read data back one cycle after each grant.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = WORD_BUS,
  parameter int STARVE_MAX = 4
) (
  input  logic                     cpu_clk_50M,
  input  logic                     cpu_rst,
  input  logic                     i_req,
  input  logic [INST_ADDR_BUS-1:0] i_addr,
  output logic                     i_ready,
  output logic                     i_rvalid,
  output logic [DATA_W-1:0]        i_rdata,
  input  logic                     d_req,
  input  logic [3:0]               d_we,
  input  logic [INST_ADDR_BUS-1:0] d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_ready,
  output logic                     d_rvalid,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     ram_ena,
  output logic [3:0]               ram_wea,
  output logic [ADDR_W-1:0]        ram_addra,
  output logic [DATA_W-1:0]        ram_dina,
  input  logic [DATA_W-1:0]        ram_douta
);

  logic   grant_i;
  logic   grant_d;
  owner_e owner_p1;
  owner_e owner_nxt;

  prio_starve_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .clk     (cpu_clk_50M),
    .rst     (cpu_rst),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign i_ready = grant_i;
  assign d_ready = grant_d;

  // Drive the RAM pins from the winner of this cycle; idle pins are zero.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 4'b0000;
    ram_addra = '0;
    ram_dina  = '0;
    if (grant_d) begin
      ram_ena   = 1'b1;
      ram_wea   = d_we;
      ram_addra = ADDR_W'(byte_to_word(d_addr));
      ram_dina  = d_wdata;
    end else if (grant_i) begin
      ram_ena   = 1'b1;
      ram_addra = ADDR_W'(byte_to_word(i_addr));
    end
  end

  // Next response owner follows this cycle's grant.
  always_comb begin
    owner_nxt = OWN_IDLE;
    if (grant_i) begin
      owner_nxt = OWN_I;
    end else if (grant_d) begin
      owner_nxt = OWN_D;
    end
  end

  // ---- stage p1: response slot, one cycle after acceptance ----
  // Response owner register; reset discards any pending response.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      owner_p1 <= OWN_IDLE;
    end else begin
      owner_p1 <= owner_nxt;
    end
  end

  assign i_rvalid = (owner_p1 == OWN_I);
  assign d_rvalid = (owner_p1 == OWN_D);
  assign i_rdata  = ram_douta;
  assign d_rdata  = ram_douta;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              cpu_clk_50M = 1'b0;
  logic              cpu_rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ready, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [3:0]        d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_ena;
  logic [3:0]        ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ready     (i_ready),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ready     (d_ready),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .ram_ena     (ram_ena),
    .ram_wea     (ram_wea),
    .ram_addra   (ram_addra),
    .ram_dina    (ram_dina),
    .ram_douta   (ram_douta)
  );

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  // Behavioural single-port RAM, 1-cycle read latency, byte write enables.
  always @(posedge cpu_clk_50M) begin
    if (ram_ena) begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
      ram_douta <= mem[ram_addra];
    end
  end

  task automatic step_drive();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1;
    d_we = 4'hF; d_addr = 32'h44; d_wdata = 32'h1;
    step_drive();
    @(negedge cpu_clk_50M);
    tests_run++;
    if ({i_ready, d_ready, ram_ena, ram_wea} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_gate: rdy/ena/wea=%b required 0", {i_ready, d_ready, ram_ena, ram_wea});
    end
    step_drive();
    cpu_rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
    @(negedge cpu_clk_50M);
    tests_run++;
    if ({i_rvalid, d_rvalid} !== 2'b00 || dut.owner_p1 !== OWN_IDLE || dut.u_sel.starve_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: rvalid=%b owner=%0d cnt=%0d required 0/IDLE/0",
               {i_rvalid, d_rvalid}, dut.owner_p1, dut.u_sel.starve_cnt);
    end
  endtask

  task automatic test_i_read();
    step_drive();
    i_req = 1'b1; i_addr = 32'h40;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (i_ready !== 1'b1 || ram_ena !== 1'b1 || ram_addra !== 11'h10 || ram_wea !== 4'h0) begin
      tests_failed++;
      $display("FAIL i_grant: rdy=%b ena=%b addra=%h wea=%h required 1 1 010 0",
               i_ready, ram_ena, ram_addra, ram_wea);
    end
    step_drive();
    i_req = 1'b0;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL i_resp: ivld=%b dvld=%b data=%h required 1 0 deadbeef", i_rvalid, d_rvalid, i_rdata);
    end
  endtask

  task automatic test_d_write_read();
    step_drive();
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h44; d_wdata = 32'h12345678;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_ready !== 1'b1 || ram_wea !== 4'b0011 || ram_addra !== 11'h11 || ram_dina !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL d_write_grant: rdy=%b wea=%b addra=%h dina=%h required 1 0011 011 12345678",
               d_ready, ram_wea, ram_addra, ram_dina);
    end
    step_drive();
    d_req = 1'b0; d_we = 4'h0;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL d_write_done: dvld=%b ivld=%b required 1 0", d_rvalid, i_rvalid);
    end
    step_drive();
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h44;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_ready !== 1'b1 || ram_wea !== 4'h0) begin
      tests_failed++;
      $display("FAIL d_read_grant: rdy=%b wea=%b required 1 0000", d_ready, ram_wea);
    end
    step_drive();
    d_req = 1'b0;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hAABB5678) begin
      tests_failed++;
      $display("FAIL d_read_data: dvld=%b data=%h required 1 aabb5678", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_contention();
    logic       exp_i [0:5];
    logic [2:0] exp_cnt [0:5];
    exp_i   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    step_drive();
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h48;
    for (int k = 0; k < 6; k++) begin
      @(negedge cpu_clk_50M);
      tests_run++;
      if (i_ready !== exp_i[k] || d_ready !== !exp_i[k] || dut.u_sel.starve_cnt !== exp_cnt[k]) begin
        tests_failed++;
        $display("FAIL contention_c%0d: irdy=%b drdy=%b cnt=%0d required %b %b %0d",
                 k, i_ready, d_ready, dut.u_sel.starve_cnt, exp_i[k], !exp_i[k], exp_cnt[k]);
      end
      if (k > 0) begin
        tests_run++;
        if (i_rvalid !== exp_i[k-1] || d_rvalid !== !exp_i[k-1] ||
            ram_douta !== (exp_i[k-1] ? 32'hDEADBEEF : 32'h0BADF00D)) begin
          tests_failed++;
          $display("FAIL contention_resp%0d: ivld=%b dvld=%b data=%h", k, i_rvalid, d_rvalid, ram_douta);
        end
      end
      step_drive();
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    step_drive();
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h48;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_d_grant: drdy=%b required 1", d_ready);
    end
    step_drive();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h40;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0BADF00D || i_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_d_resp: dvld=%b data=%h irdy=%b required 1 0badf00d 1", d_rvalid, d_rdata, i_ready);
    end
    step_drive();
    i_req = 1'b0;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL b2b_i_resp: ivld=%b dvld=%b data=%h required 1 0 deadbeef", i_rvalid, d_rvalid, i_rdata);
    end
  endtask

  task automatic test_reset_mid();
    step_drive();
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h48;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (d_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_grant: drdy=%b required 1", d_ready);
    end
    step_drive();
    d_req = 1'b0; cpu_rst = 1'b1; i_req = 1'b1; i_addr = 32'h40;
    @(negedge cpu_clk_50M);
    tests_run++;
    if (ram_ena !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_gate: ena=%b irdy=%b drdy=%b required 0 0 0", ram_ena, i_ready, d_ready);
    end
    step_drive();
    cpu_rst = 1'b0; i_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge cpu_clk_50M);
      tests_run++;
      if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || dut.owner_p1 !== OWN_IDLE || dut.u_sel.starve_cnt !== 3'd0) begin
        tests_failed++;
        $display("FAIL rstmid_after%0d: dvld=%b ivld=%b owner=%0d cnt=%0d required 0 0 IDLE 0",
                 k, d_rvalid, i_rvalid, dut.owner_p1, dut.u_sel.starve_cnt);
      end
      step_drive();
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge cpu_clk_50M);
      tests_run++;
      if ({ram_ena, i_ready, d_ready, i_rvalid, d_rvalid} !== 5'b0) begin
        tests_failed++;
        $display("FAIL idle_c%0d: ena/irdy/drdy/ivld/dvld=%b required 00000",
                 k, {ram_ena, i_ready, d_ready, i_rvalid, d_rvalid});
      end
      step_drive();
    end
  endtask

  initial begin
    mem[11'h10] = 32'hDEADBEEF;
    mem[11'h11] = 32'hAABBCCDD;
    mem[11'h12] = 32'h0BADF00D;
    test_reset();
    test_i_read();
    test_d_write_read();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port block RAM between the instruction-fetch requester and the data-access requester of the MiniMIPS32 core.
- The RAM is unified, with 1-cycle read latency and ena/wea[3:0]/addra/dina/douta pins.
- The arbiter uses fixed priority (data over instruction) with a starvation guard.
- It sits between the core's I/D ports and the unified RAM in the SoC top.

Parameters:
- ADDR_W, 11, RAM word-address width (ram_addra width)
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive instruction-side denials before instruction side is forced to win

Ports:
- cpu_clk_50M  in  1  system clock, all logic on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held with i_addr until i_ready
- i_addr  in  32  instruction byte address
- i_ready  out  1  instruction request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  DATA_W  instruction read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  4  byte write enables; 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  data completion (read data valid, or write done)
- d_rdata  out  DATA_W  data read data
- ram_ena  out  1  RAM enable
- ram_wea  out  4  RAM byte write enables
- ram_addra  out  ADDR_W  RAM word address
- ram_dina  out  DATA_W  RAM write data
- ram_douta  in  DATA_W  RAM read data, valid 1 cycle after ena

Behaviour:
- Acceptance: a request is accepted in any cycle where req && ready. At most one grant per cycle. Back-to-back grants are allowed, giving a throughput of 1 access per cycle.
- Grant rule, combinational:
  - If cpu_rst is high, no grant.
  - Otherwise, if i_req && starve_cnt == STARVE_MAX, grant I.
  - Otherwise, if d_req, grant D.
  - Otherwise, if i_req, grant I.
- RAM drive in the grant cycle, combinational from the winner:
  - ram_ena = 1.
  - ram_addra = addr[ADDR_W+1:2]; addr[1:0] and the high bits are ignored.
  - I grant: ram_wea = 0.
  - D grant: ram_wea = d_we, ram_dina = d_wdata.
  - No grant: ram_ena = 0, ram_wea = 0, ram_addra/ram_dina = 0.
- Response FSM, registered owner, states IDLE / RESP_I / RESP_D:
  - Next state = RESP_I on I grant, RESP_D on D grant, else IDLE.
  - In RESP_I: i_rvalid = 1.
  - In RESP_D: d_rvalid = 1 for both reads and writes.
  - Latency is exactly 1 cycle from acceptance to rvalid.
- Read data: i_rdata and d_rdata are both driven from ram_douta; they are valid only when the corresponding rvalid is high.
- Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
  - Increments when i_req && !i_ready, saturating at STARVE_MAX.
  - Clears on I grant or when i_req is low.
- Simultaneous events:
  - Both requests with starve_cnt < STARVE_MAX: D wins and the counter increments.
  - Both requests with starve_cnt == STARVE_MAX: I wins, the counter clears, and D waits 1 cycle.
- Reset:
  - While cpu_rst is high: i_ready = d_ready = 0, ram_ena = 0, ram_wea = 0.
  - Next cycle: state IDLE, i_rvalid = d_rvalid = 0, starve_cnt = 0.
  - A response pending when reset asserts is discarded; no rvalid is issued after reset.
- Requesters must not drop req before ready. The arbiter does not check this; the behaviour on a violation is that the request is simply not accepted.

Decomposition:
- Shared package: owner-state encodings (OWN_IDLE/OWN_I/OWN_D), the RAM address-slice helper, and the width constants reused from the codebase-wide defines (WORD_BUS, INST_ADDR_BUS).
- One natural sub-module, prio_starve_sel: the grant selector plus the starvation counter. The top module holds the response FSM and the RAM muxing.

Test Plan:
- I-only read: preload RAM word 0x10 = 0xDEADBEEF; i_req = 1, i_addr = 0x40 -> i_ready = 1 the same cycle, ram_addra = 0x10, ram_wea = 0; next cycle i_rvalid = 1, i_rdata = 0xDEADBEEF.
- D write then read: d_we = 4'b0011, d_addr = 0x44, d_wdata = 0x12345678 onto word 0xAABBCCDD -> d_rvalid next cycle; read of 0x44 returns 0xAABB5678.
- Contention with STARVE_MAX = 4: i_req and d_req held high for 6 cycles -> grants D, D, D, D, I, D; starve_cnt reaches 4 then clears after the I grant.
- Back-to-back: D accepted at cycle n, I at n+1 -> d_rvalid at n+1, i_rvalid at n+2, each carrying the correct douta.
- Reset mid-operation: D read accepted at cycle n, cpu_rst = 1 during n+1 -> d_rvalid = 0 from n+2 on, ram_ena = 0 while in reset, state IDLE and starve_cnt = 0 after reset.
- Idle: no requests -> ram_ena = 0, ready = 0, no rvalid for 20 cycles.
